// File: rtl/sub8_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub8_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Bit-counter width: wide enough to index bits 0..w-1, never zero.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sub8_serial_fs1.sv
// sub_fs1: combinational 1-bit full subtractor computing a - b - bin.
module sub_fs1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub8_serial.sv
// sub8_serial: bit-serial WIDTH-bit subtractor, O = {borrow, A - B}, with
// valid/ready handshakes on both sides. One bit is processed per clock, LSB
// first. Optional signed-overflow output is enabled by defining the macro
// SUB8_SERIAL_OVF_FLAG_EN.
module sub8_serial
  import sub8_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef SUB8_SERIAL_OVF_FLAG_EN
  output logic           ovf,
`endif
  output logic [WIDTH:0] O
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]   o_q, o_d;
  logic             fs_d, fs_bout;

  sub_fs1 u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    o_d       = o_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        res_d    = {fs_d, res_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish the finished result; O then stays put until the next one.
          o_d     = {fs_bout, fs_d, res_q[WIDTH-1:1]};
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including O.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      o_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      o_q      <= o_d;
    end
  end

  assign O = o_q;

`ifdef SUB8_SERIAL_OVF_FLAG_EN
  logic amsb_q, amsb_d;
  logic bmsb_q, bmsb_d;
  logic ovf_q, ovf_d;

  // Operand sign bits are captured at acceptance since the shift registers
  // lose them; overflow is resolved alongside the final difference bit.
  always_comb begin
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    ovf_d  = ovf_q;
    if (state_q == IDLE && in_valid) begin
      amsb_d = A[WIDTH-1];
      bmsb_d = B[WIDTH-1];
    end
    if (state_q == SHIFT && cnt_q == LAST) begin
      ovf_d = (amsb_q != bmsb_q) && (fs_d != amsb_q);
    end
  end

  // Overflow flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sub8_serial.sv
// Self-checking bench for sub8_serial (WIDTH=8): directed steps plus a
// random batch, expected results queued at acceptance and popped at output.
module tb_sub8_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] O;
  logic       ovf_w;

  int compared   = 0;
  int mismatched = 0;

  logic [9:0] sb_q[$];  // {ovf, O}

  always #5 clk = ~clk;

  sub8_serial #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SUB8_SERIAL_OVF_FLAG_EN
    .ovf       (ovf_w),
`endif
    .O         (O)
  );

`ifndef SUB8_SERIAL_OVF_FLAG_EN
  assign ovf_w = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] o;
    logic       v;
    o = {1'b0, a} - {1'b0, b};
    v = (a[7] != b[7]) && (o[7] != a[7]);
    return {v, o};
  endfunction

  // One operation: accept (a,b), optionally hold out_ready low for `hold`
  // cycles, optionally wiggle in_valid/A/B while shifting.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int hold, input bit noise, input string tag);
    logic [9:0] exp;
    logic [8:0] o_seen;
    int lat;
    check({tag, ".in_ready_idle"}, in_ready, 1);
    A = a; B = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    sb_q.push_back(model(a, b));
    tick();
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        in_valid = 1'($urandom);
        A = 8'($urandom); B = 8'($urandom);
      end
      check({tag, ".no_ready_in_shift"}, in_ready, 0);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, lat, 8);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
    check({tag, ".O"}, O, {23'd0, exp[8:0]});
`ifdef SUB8_SERIAL_OVF_FLAG_EN
    check({tag, ".ovf"}, ovf_w, exp[9]);
`endif
    o_seen = O;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_in_ready"}, in_ready, 0);
      check({tag, ".hold_O"}, O, o_seen);
    end
    out_ready = 1'b1;
    tick();
    check({tag, ".idle_valid"}, out_valid, 0);
    check({tag, ".idle_in_ready"}, in_ready, 1);
    check({tag, ".O_kept"}, O, o_seen);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.O", O, 0);
    check("reset.ovf", ovf_w, 0);

    run_op(8'd200, 8'd55, 0, 1'b0, "t200_55");
    check("t200_55.abs", O, 9'h091);
    run_op(8'd5, 8'd10, 0, 1'b0, "t5_10");
    check("t5_10.abs", O, 9'h1FB);
    run_op(8'd0, 8'd255, 0, 1'b0, "t0_255");
    check("t0_255.abs", O, 9'h101);
    run_op(8'd77, 8'd77, 0, 1'b0, "t77_77");
    check("t77_77.abs", O, 9'h000);

    run_op(8'd3, 8'd1, 5, 1'b0, "bp3_1");
    check("bp3_1.abs", O, 9'h002);

    // Reset while shifting: accept, let 3 bits go, reset on the 4th.
    A = 8'd100; B = 8'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid.in_ready", in_ready, 1);
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.O", O, 0);
    check("rst_mid.ovf", ovf_w, 0);
    run_op(8'd9, 8'd4, 0, 1'b0, "after_rst");
    check("after_rst.abs", O, 9'h005);

    run_op(8'd150, 8'd33, 0, 1'b1, "noise1");
    run_op(8'd12, 8'd240, 2, 1'b1, "noise2");

    run_op(8'h80, 8'h01, 0, 1'b0, "ovf80_01");
    check("ovf80_01.abs", O, 9'h07F);
`ifdef SUB8_SERIAL_OVF_FLAG_EN
    check("ovf80_01.flag", ovf_w, 1);
`endif
    run_op(8'h10, 8'h01, 0, 1'b0, "ovf10_01");
`ifdef SUB8_SERIAL_OVF_FLAG_EN
    check("ovf10_01.flag", ovf_w, 0);
`endif

    for (int k = 0; k < 300; k++) begin
      run_op(8'($urandom), 8'($urandom), (k % 7 == 0) ? 1 : 0, 1'(k % 5 == 0), "rand");
    end

    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
